// File: rtl/snake_head_stepper.sv
// snake_head_stepper: per-player movement stage for the snake game.
// Produces one validated head step per game tick over valid/ready.
module snake_head_stepper #(
    parameter int unsigned GRID_W    = 40,
    parameter int unsigned GRID_H    = 30,
    parameter int unsigned XW        = 6,
    parameter int unsigned YW        = 5,
    parameter int unsigned TICK_DIV  = 2517500,
    parameter int unsigned START_X   = 30,
    parameter int unsigned START_Y   = 15,
    parameter logic [1:0]  START_DIR = 2'b11,
    parameter bit          WRAP      = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          run,
    input  logic          restart,
    input  logic [1:0]    dir_in,
    output logic [1:0]    cur_dir,
    output logic [XW-1:0] head_x,
    output logic [YW-1:0] head_y,
    output logic [XW-1:0] next_x,
    output logic [YW-1:0] next_y,
    output logic          step_valid,
    input  logic          step_ready,
    output logic          wall_hit
);

    localparam int unsigned CW = $clog2(TICK_DIV);

    localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);
    localparam logic [XW-1:0] X_MAX   = XW'(GRID_W - 1);
    localparam logic [YW-1:0] Y_MAX   = YW'(GRID_H - 1);
    localparam logic [XW-1:0] X_START = XW'(START_X);
    localparam logic [YW-1:0] Y_START = YW'(START_Y);

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_RIGHT = 2'b01;
    localparam logic [1:0] DIR_DOWN  = 2'b10;
    localparam logic [1:0] DIR_LEFT  = 2'b11;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_VALID = 2'd2;
    localparam logic [1:0] S_DEAD  = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    cur_dir_q, cur_dir_d;
    logic [XW-1:0] head_x_q, head_x_d;
    logic [YW-1:0] head_y_q, head_y_d;
    logic [XW-1:0] next_x_q, next_x_d;
    logic [YW-1:0] next_y_q, next_y_d;
    logic          valid_q, valid_d;
    logic          wall_q, wall_d;

    logic          reversal;
    logic [1:0]    step_dir;
    logic          at_edge;
    logic [XW-1:0] mv_x;
    logic [YW-1:0] mv_y;

    // Candidate step: filter 180-degree reversals, then move with bounded wrap.
    always_comb begin
        reversal = ((dir_in ^ cur_dir_q) == 2'b10);
        step_dir = reversal ? cur_dir_q : dir_in;
        at_edge  = 1'b0;
        mv_x     = head_x_q;
        mv_y     = head_y_q;
        case (step_dir)
            DIR_UP: begin
                at_edge = (head_y_q == '0);
                mv_y    = at_edge ? Y_MAX : head_y_q - YW'(1);
            end
            DIR_RIGHT: begin
                at_edge = (head_x_q == X_MAX);
                mv_x    = at_edge ? '0 : head_x_q + XW'(1);
            end
            DIR_DOWN: begin
                at_edge = (head_y_q == Y_MAX);
                mv_y    = at_edge ? '0 : head_y_q + YW'(1);
            end
            default: begin
                at_edge = (head_x_q == '0);
                mv_x    = at_edge ? X_MAX : head_x_q - XW'(1);
            end
        endcase
    end

    // Tick/handshake FSM; restart overrides everything.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cur_dir_d = cur_dir_q;
        head_x_d  = head_x_q;
        head_y_d  = head_y_q;
        next_x_d  = next_x_q;
        next_y_d  = next_y_q;
        valid_d   = valid_q;
        wall_d    = wall_q;
        if (restart) begin
            state_d   = S_IDLE;
            cnt_d     = '0;
            cur_dir_d = START_DIR;
            head_x_d  = X_START;
            head_y_d  = Y_START;
            next_x_d  = X_START;
            next_y_d  = Y_START;
            valid_d   = 1'b0;
            wall_d    = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    cnt_d = '0;
                    if (run) begin
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!run) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_MAX) begin
                        cnt_d     = '0;
                        cur_dir_d = step_dir;
                        if (at_edge && !WRAP) begin
                            wall_d  = 1'b1;
                            state_d = S_DEAD;
                        end else begin
                            next_x_d = mv_x;
                            next_y_d = mv_y;
                            valid_d  = 1'b1;
                            state_d  = S_VALID;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                S_VALID: begin
                    if (step_ready) begin
                        head_x_d = next_x_q;
                        head_y_d = next_y_q;
                        valid_d  = 1'b0;
                        state_d  = run ? S_WAIT : S_IDLE;
                    end
                end
                default: begin
                    state_d = S_DEAD;
                end
            endcase
        end
    end

    // State registers with asynchronous reset to the start position.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            cur_dir_q <= START_DIR;
            head_x_q  <= X_START;
            head_y_q  <= Y_START;
            next_x_q  <= X_START;
            next_y_q  <= Y_START;
            valid_q   <= 1'b0;
            wall_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cur_dir_q <= cur_dir_d;
            head_x_q  <= head_x_d;
            head_y_q  <= head_y_d;
            next_x_q  <= next_x_d;
            next_y_q  <= next_y_d;
            valid_q   <= valid_d;
            wall_q    <= wall_d;
        end
    end

    assign cur_dir    = cur_dir_q;
    assign head_x     = head_x_q;
    assign head_y     = head_y_q;
    assign next_x     = next_x_q;
    assign next_y     = next_y_q;
    assign step_valid = valid_q;
    assign wall_hit   = wall_q;

endmodule

// File: tb/tb_snake_head_stepper.sv
// tb_snake_head_stepper: directed checks of cadence, reversal, wrap,
// wall, backpressure and restart for snake_head_stepper.
module tb_snake_head_stepper;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       restart;
    logic       step_ready;
    logic [1:0] dir_in;
    logic       run_a, run_b, run_c;

    logic [1:0] cd_a, cd_b, cd_c;
    logic [5:0] hx_a, hx_b, hx_c, nx_a, nx_b, nx_c;
    logic [4:0] hy_a, hy_b, hy_c, ny_a, ny_b, ny_c;
    logic       sv_a, sv_b, sv_c, wh_a, wh_b, wh_c;

    snake_head_stepper #(.TICK_DIV(4)) u_a (
        .clk(clk), .rst_n(rst_n), .run(run_a), .restart(restart),
        .dir_in(dir_in), .cur_dir(cd_a), .head_x(hx_a), .head_y(hy_a),
        .next_x(nx_a), .next_y(ny_a), .step_valid(sv_a),
        .step_ready(step_ready), .wall_hit(wh_a)
    );

    snake_head_stepper #(.TICK_DIV(4), .START_X(0), .START_Y(0)) u_b (
        .clk(clk), .rst_n(rst_n), .run(run_b), .restart(restart),
        .dir_in(dir_in), .cur_dir(cd_b), .head_x(hx_b), .head_y(hy_b),
        .next_x(nx_b), .next_y(ny_b), .step_valid(sv_b),
        .step_ready(step_ready), .wall_hit(wh_b)
    );

    snake_head_stepper #(.TICK_DIV(4), .START_X(0), .START_Y(5),
                         .WRAP(1'b0)) u_c (
        .clk(clk), .rst_n(rst_n), .run(run_c), .restart(restart),
        .dir_in(dir_in), .cur_dir(cd_c), .head_x(hx_c), .head_y(hy_c),
        .next_x(nx_c), .next_y(ny_c), .step_valid(sv_c),
        .step_ready(step_ready), .wall_hit(wh_c)
    );

    int sel = 0;
    logic [31:0] m_cd, m_hx, m_hy, m_nx, m_ny, m_sv, m_wh;

    always_comb begin
        m_cd = 32'(cd_a); m_hx = 32'(hx_a); m_hy = 32'(hy_a);
        m_nx = 32'(nx_a); m_ny = 32'(ny_a);
        m_sv = 32'(sv_a); m_wh = 32'(wh_a);
        case (sel)
            1: begin
                m_cd = 32'(cd_b); m_hx = 32'(hx_b); m_hy = 32'(hy_b);
                m_nx = 32'(nx_b); m_ny = 32'(ny_b);
                m_sv = 32'(sv_b); m_wh = 32'(wh_b);
            end
            2: begin
                m_cd = 32'(cd_c); m_hx = 32'(hx_c); m_hy = 32'(hy_c);
                m_nx = 32'(nx_c); m_ny = 32'(ny_c);
                m_sv = 32'(sv_c); m_wh = 32'(wh_c);
            end
            default: ;
        endcase
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_sv(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (m_sv[0]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk({name, "_timeout"}, 0, 1);
    endtask

    typedef struct {
        int dir;
        int ecd;
        int ex;
        int ey;
    } vec_t;

    vec_t va[8];
    vec_t vb[4];

    initial begin
        int prev;
        int t0;
        bit bad;

        va[0] = '{1, 3, 29, 15};
        va[1] = '{0, 0, 29, 14};
        va[2] = '{1, 1, 30, 14};
        va[3] = '{1, 1, 31, 14};
        va[4] = '{1, 1, 32, 14};
        va[5] = '{2, 2, 32, 15};
        va[6] = '{0, 2, 32, 16};
        va[7] = '{3, 3, 31, 16};

        vb[0] = '{3, 3, 39, 0};
        vb[1] = '{0, 0, 39, 29};
        vb[2] = '{1, 1, 0, 29};
        vb[3] = '{2, 2, 0, 0};

        rst_n = 1'b0; restart = 1'b0; step_ready = 1'b1;
        dir_in = 2'b11; run_a = 1'b0; run_b = 1'b0; run_c = 1'b0;
        repeat (3) @(negedge clk);
        sel = 0;
        #1;
        chk("rst_hx", m_hx, 30);
        chk("rst_hy", m_hy, 15);
        chk("rst_cd", m_cd, 3);
        chk("rst_sv", m_sv, 0);
        chk("rst_wh", m_wh, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_a = 1'b1;
        prev = 0;
        for (int i = 0; i < 8; i++) begin
            dir_in = 2'(va[i].dir);
            wait_sv($sformatf("a%0d", i));
            chk($sformatf("a%0d_cd", i), m_cd, 32'(va[i].ecd));
            chk($sformatf("a%0d_nx", i), m_nx, 32'(va[i].ex));
            chk($sformatf("a%0d_ny", i), m_ny, 32'(va[i].ey));
            if (i > 0) chk($sformatf("a%0d_period", i), cyc - prev, 5);
            prev = cyc;
            @(negedge clk);
            chk($sformatf("a%0d_hx", i), m_hx, 32'(va[i].ex));
            chk($sformatf("a%0d_hy", i), m_hy, 32'(va[i].ey));
            chk($sformatf("a%0d_pulse", i), m_sv, 0);
        end

        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_hx", m_hx, 30);
        chk("arst_hy", m_hy, 15);
        chk("arst_nx", m_nx, 30);
        chk("arst_ny", m_ny, 15);
        chk("arst_cd", m_cd, 3);
        chk("arst_sv", m_sv, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_a = 1'b0;
        @(negedge clk);

        step_ready = 1'b0;
        dir_in = 2'b11;
        run_a = 1'b1;
        wait_sv("bp");
        chk("bp_nx", m_nx, 29);
        chk("bp_cd", m_cd, 3);
        for (int k = 0; k < 3; k++) begin
            dir_in = 2'(k);
            run_a = k[0];
            @(negedge clk);
            chk($sformatf("bp%0d_sv", k), m_sv, 1);
            chk($sformatf("bp%0d_nx", k), m_nx, 29);
            chk($sformatf("bp%0d_ny", k), m_ny, 15);
            chk($sformatf("bp%0d_cd", k), m_cd, 3);
            chk($sformatf("bp%0d_hx", k), m_hx, 30);
        end
        run_a = 1'b1;
        dir_in = 2'b00;
        step_ready = 1'b1;
        @(negedge clk);
        chk("bp_acc_hx", m_hx, 29);
        chk("bp_acc_sv", m_sv, 0);
        t0 = cyc;
        wait_sv("bp_next");
        chk("bp_next_delay", cyc - t0, 4);
        chk("bp_next_ny", m_ny, 14);
        chk("bp_next_cd", m_cd, 0);

        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        chk("rc_hx", m_hx, 30);
        chk("rc_hy", m_hy, 15);
        chk("rc_nx", m_nx, 30);
        chk("rc_sv", m_sv, 0);
        chk("rc_cd", m_cd, 3);
        t0 = cyc;
        wait_sv("rc_resume");
        chk("rc_resume_delay", cyc - t0, 5);
        chk("rc_resume_ny", m_ny, 14);
        run_a = 1'b0;
        @(negedge clk);

        sel = 1;
        run_b = 1'b1;
        for (int i = 0; i < 4; i++) begin
            dir_in = 2'(vb[i].dir);
            wait_sv($sformatf("b%0d", i));
            chk($sformatf("b%0d_cd", i), m_cd, 32'(vb[i].ecd));
            chk($sformatf("b%0d_nx", i), m_nx, 32'(vb[i].ex));
            chk($sformatf("b%0d_ny", i), m_ny, 32'(vb[i].ey));
            @(negedge clk);
            chk($sformatf("b%0d_hx", i), m_hx, 32'(vb[i].ex));
        end
        run_b = 1'b0;
        @(negedge clk);

        sel = 2;
        dir_in = 2'b11;
        run_c = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (m_sv[0]) bad = 1'b1;
        end
        chk("wall_hit", m_wh, 1);
        for (int i = 0; i < 100; i++) begin
            dir_in = 2'(i % 4);
            @(negedge clk);
            if (m_sv[0] || !m_wh[0] || m_hx != 0 || m_nx != 0
                || m_hy != 5 || m_cd != 3) bad = 1'b1;
        end
        chk("dead_frozen", 32'(bad), 0);
        chk("dead_hx", m_hx, 0);
        chk("dead_hy", m_hy, 5);
        run_c = 1'b0;
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        chk("dead_rs_wh", m_wh, 0);
        chk("dead_rs_sv", m_sv, 0);
        chk("dead_rs_hx", m_hx, 0);
        chk("dead_rs_hy", m_hy, 5);
        chk("dead_rs_cd", m_cd, 3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
